// File: rtl/cmd_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_responder : chain-tail responder with register file, buffered responses
//                 and unique-address write coverage.   Revision 1.0
// ----------------------------------------------------------------------------
module cmd_responder #(
  parameter int CMD_W     = 2,
  parameter int ADR_W     = 3,
  parameter int DATA_W    = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_W-1:0]      cmd_in,
  input  logic [ADR_W-1:0]      adr_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADR_W-1:0]      rsp_adr,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  input  logic                  cov_clr,
  output logic [2**ADR_W-1:0]   hit_map,
  output logic [ADR_W:0]        unique_cnt,
  output logic                  all_hit,
  output logic [7:0]            err_cnt
);
  localparam int c_num_ent = 2**ADR_W;
  localparam int c_ptr_w   = $clog2(RSP_DEPTH);
  localparam int c_ent_w   = ADR_W + DATA_W + 1;
  localparam logic [CMD_W-1:0] c_cmd_idle  = CMD_W'(0);
  localparam logic [CMD_W-1:0] c_cmd_read  = CMD_W'(1);
  localparam logic [CMD_W-1:0] c_cmd_write = CMD_W'(2);

  logic [DATA_W-1:0]    mem_q  [c_num_ent];
  logic [c_ent_w-1:0]   fifo_q [RSP_DEPTH];
  logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]     cnt_q, cnt_d;
  logic [c_num_ent-1:0] hit_map_q, hit_map_d;
  logic [ADR_W:0]       unique_cnt_q, unique_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic                 w_accept, w_wr, w_rd, w_rsvd, w_push, w_pop;
  logic [c_ent_w-1:0]   w_push_entry, w_head;

  assign busy     = (cnt_q == (c_ptr_w+1)'(RSP_DEPTH));
  assign w_accept = (cmd_in != c_cmd_idle) && !busy;
  assign w_wr     = w_accept && (cmd_in == c_cmd_write);
  assign w_rd     = w_accept && (cmd_in == c_cmd_read);
  assign w_rsvd   = w_accept && !w_wr && !w_rd;
  assign w_push   = w_rd || w_rsvd;
  assign w_pop    = rsp_valid && rsp_ready;

  // Reserved commands carry zero data; reads sample mem before this edge's write.
  assign w_push_entry = {adr_in, (w_rd ? mem_q[adr_in] : {DATA_W{1'b0}}), w_rsvd};

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + (c_ptr_w+1)'(1);
      2'b01:   cnt_d = cnt_q - (c_ptr_w+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    hit_map_d    = hit_map_q;
    unique_cnt_d = unique_cnt_q;
    if (cov_clr) begin
      hit_map_d    = w_wr ? (c_num_ent'(1) << adr_in) : '0;
      unique_cnt_d = w_wr ? (ADR_W+1)'(1) : '0;
    end else if (w_wr && !hit_map_q[adr_in]) begin
      hit_map_d[adr_in] = 1'b1;
      unique_cnt_d      = unique_cnt_q + (ADR_W+1)'(1);
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_rsvd && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // FIFO storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_num_ent; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hit_map_q    <= '0;
      unique_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (w_wr) begin
        mem_q[adr_in] <= data_in;
      end
      if (w_push) begin
        fifo_q[wr_ptr_q] <= w_push_entry;
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      hit_map_q    <= hit_map_d;
      unique_cnt_q <= unique_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rsp_valid  = (cnt_q != '0);
  assign w_head     = rsp_valid ? fifo_q[rd_ptr_q] : '0;
  assign rsp_adr    = w_head[c_ent_w-1 -: ADR_W];
  assign rsp_data   = w_head[DATA_W:1];
  assign rsp_err    = w_head[0];
  assign hit_map    = hit_map_q;
  assign unique_cnt = unique_cnt_q;
  assign all_hit    = (unique_cnt_q == (ADR_W+1)'(c_num_ent));
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/cmd_responder.md
Name: cmd_responder

Overview:
- Terminal responder for the dut_if cmd/adr/data channel. It sits on the master-side interface at the tail of a dut chain and consumes the transactions the chain forwards.
- Holds a small register file that is written by write commands and returned on read commands through a buffered valid/ready response port.
- Tracks unique-address write coverage: a hit bitmap, a unique-address count and an all-hit flag.

Parameters:
- CMD_W, 2, width of cmd_in.
- ADR_W, 3, address width; the register file has 2**ADR_W entries.
- DATA_W, 3, data width of the register file and the response.
- RSP_DEPTH, 4, response FIFO depth; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_in  in  CMD_W  0 idle, 1 read, 2 write, 3 reserved (error).
- adr_in  in  ADR_W  transaction address.
- data_in  in  DATA_W  write data.
- busy  out  1  response FIFO full; upstream holds cmd/adr/data stable while busy is high.
- rsp_valid  out  1  FIFO head is valid.
- rsp_ready  in  1  downstream accepts the head.
- rsp_adr  out  ADR_W  address of the head response.
- rsp_data  out  DATA_W  read data of the head response.
- rsp_err  out  1  head response is from a reserved command.
- cov_clr  in  1  clear coverage state.
- hit_map  out  2**ADR_W  bit i is set once address i has been written.
- unique_cnt  out  ADR_W+1  popcount of hit_map.
- all_hit  out  1  unique_cnt == 2**ADR_W.
- err_cnt  out  8  count of reserved commands, saturating at 255.

Behaviour:
- Reset (rst sampled high at posedge) sets:
  - all register-file entries to 0 and the FIFO to empty;
  - busy, rsp_valid, rsp_adr, rsp_data and rsp_err to 0;
  - hit_map, unique_cnt, all_hit and err_cnt to 0.
- Reset mid-operation drops every queued response; a pending rsp_ready has no effect in that cycle.
- busy is combinational: it equals (FIFO count == RSP_DEPTH).
- Acceptance: a transaction is accepted at a posedge where cmd_in != 0 and busy == 0. While busy is high, every command type is ignored, including writes; upstream re-presents it.
- Write (cmd 2):
  - mem[adr_in] <= data_in.
  - hit_map[adr_in] <= 1; unique_cnt and all_hit are updated in the same edge.
  - No response is queued.
- Read (cmd 1): pushes {adr_in, mem[adr_in], err=0}. mem is read before that edge's update, which cannot conflict because there is only one command per cycle.
- Reserved (cmd 3):
  - pushes {adr_in, 0, err=1};
  - err_cnt increments and saturates at 255;
  - mem and coverage are unchanged.
- Latency:
  - A read accepted at edge N into an empty FIFO gives rsp_valid=1 with its data after edge N (visible in cycle N+1).
  - Back-to-back reads return in order, one per cycle while rsp_ready=1.
- Pop: occurs at the edge where rsp_valid and rsp_ready are both 1.
  - Push and pop in the same edge leave the count unchanged.
  - Pop when empty does nothing.
  - Pop when full frees a slot, so busy falls in the next cycle. A command presented during the full cycle is not accepted.
- FIFO pointers wrap modulo RSP_DEPTH; a full FIFO and an empty FIFO are distinguished by the count.
- A write to an address whose hit_map bit is already set leaves unique_cnt unchanged.
- cov_clr has priority over coverage updates:
  - hit_map <= 0, unique_cnt <= 0, all_hit <= 0.
  - If a write is accepted in the same edge: hit_map <= (1 << adr_in), unique_cnt <= 1.
  - cov_clr does not affect mem, the FIFO or err_cnt.
- rsp_* outputs hold their value while rsp_valid=1 and rsp_ready=0. When rsp_valid=0, rsp_adr, rsp_data and rsp_err are 0.

Test Plan:
- After reset: cmd 2 adr 3 data 5, then cmd 1 adr 3 → rsp_valid one cycle after the read edge, with rsp_adr=3, rsp_data=5, rsp_err=0; hit_map=8'h08, unique_cnt=1.
- Random writes (cmd 2, adr 3..4, data 0..7) for 100 cycles → hit_map=8'h18, unique_cnt=2, all_hit=0. Then write adr 0,1,2,5,6,7 → unique_cnt=8, all_hit=1.
- rsp_ready=0, five reads to adr 0..4 → the first four are queued, busy=1 during the fifth and it is not accepted. Raise rsp_ready → adr 0,1,2,3 drain in order; the held fifth read is then accepted and returns adr 4.
- cmd 3 adr 6 issued 257 times with rsp_ready=1 → 257 responses with rsp_err=1 and rsp_data=0; err_cnt=255; mem and hit_map unchanged.
- cov_clr=1 in the same edge as a write to adr 2 after full coverage → hit_map=8'h04, unique_cnt=1, all_hit=0; a subsequent read of adr 2 returns the written data.
- Assert rst with 3 responses queued and rsp_ready=1 → next cycle rsp_valid=0, busy=0, err_cnt=0; a read of any address returns 0.
